// File: rtl/ddr_ring_streamer_if.sv
// ----------------------------------------------------------------------------
// ddr_ring_streamer_if
// Avalon-MM bus between the ring streamer (master) and the DDR controller
// (slave).
//
// Handshake: a request (avl_write_req or avl_read_req) is transferred on every
// rising clk edge where the request and avl_ready are both high. While
// avl_ready is low the master holds the request, address, burstbegin and write
// data stable. avl_rdata_valid has no back-pressure: each high cycle delivers
// one read beat.
//
// Signals
//   avl_ready        slave -> master  controller accepts current request
//   avl_burstbegin   master -> slave  first beat of a command
//   avl_address      master -> slave  command word address
//   avl_size         master -> slave  burst length in words
//   avl_read_req     master -> slave  read command
//   avl_write_req    master -> slave  write beat
//   avl_wdata        master -> slave  write beat data
//   avl_be           master -> slave  byte enables
//   avl_rdata_valid  slave -> master  read beat valid
//   avl_rdata        slave -> master  read beat data
// ----------------------------------------------------------------------------
interface ddr_ring_streamer_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 25
);
    logic                  avl_ready;
    logic                  avl_burstbegin;
    logic [ADDR_W-1:0]     avl_address;
    logic [7:0]            avl_size;
    logic                  avl_read_req;
    logic                  avl_write_req;
    logic [DATA_W-1:0]     avl_wdata;
    logic [DATA_W/8-1:0]   avl_be;
    logic                  avl_rdata_valid;
    logic [DATA_W-1:0]     avl_rdata;

    modport master (
        input  avl_ready,
        input  avl_rdata_valid,
        input  avl_rdata,
        output avl_burstbegin,
        output avl_address,
        output avl_size,
        output avl_read_req,
        output avl_write_req,
        output avl_wdata,
        output avl_be
    );

    modport slave (
        output avl_ready,
        output avl_rdata_valid,
        output avl_rdata,
        input  avl_burstbegin,
        input  avl_address,
        input  avl_size,
        input  avl_read_req,
        input  avl_write_req,
        input  avl_wdata,
        input  avl_be
    );
endinterface

// File: rtl/ddr_ring_streamer.sv
// ----------------------------------------------------------------------------
// ddr_ring_streamer
// Streams words from a show-ahead input FIFO into a DDR ring region as
// Avalon-MM write bursts and reads them back, in order, into an output FIFO.
// A single engine alternates between write and read bursts (round-robin when
// both are eligible) and tracks ring occupancy with wrap-around pointers.
//
// Optional feature: define DDR_STREAM_STATS_EN to add saturating burst
// counters stat_wr_bursts / stat_rd_bursts.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   calib_done          no command is issued while low
//   writes_en/reads_en  burst enables, sampled in IDLE
//   clear               IDLE-only pulse: zero pointers, fill, overflow, stats
//   region_base         ring start word address
//   region_words        ring size in words (nonzero multiple of BURST_LEN)
//   ib_re/ib_data/ib_count   input FIFO pop / head word / occupancy
//   ob_we/ob_data/ob_count   output FIFO push / data / occupancy
//   avl                 Avalon-MM master bus (see ddr_ring_streamer_if)
//   fill_words          words written and not yet read-requested
//   overflow            sticky: ring full while input FIFO full
//   busy                engine not in IDLE
//   dbg_state           current FSM state
// ----------------------------------------------------------------------------
module ddr_ring_streamer #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 25,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 256,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                calib_done,
    input  logic                writes_en,
    input  logic                reads_en,
    input  logic                clear,
    input  logic [ADDR_W-1:0]   region_base,
    input  logic [ADDR_W-1:0]   region_words,
    output logic                ib_re,
    input  logic [DATA_W-1:0]   ib_data,
    input  logic [CNT_W-1:0]    ib_count,
    output logic                ob_we,
    output logic [DATA_W-1:0]   ob_data,
    input  logic [CNT_W-1:0]    ob_count,
    ddr_ring_streamer_if.master avl,
    output logic [ADDR_W:0]     fill_words,
    output logic                overflow,
    output logic                busy,
    output logic [1:0]          dbg_state
`ifdef DDR_STREAM_STATS_EN
    ,
    output logic [31:0]         stat_wr_bursts,
    output logic [31:0]         stat_rd_bursts
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_DATA  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   BL_FILL = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W+1:0] BL_EXT  = (ADDR_W+2)'(BURST_LEN);
    localparam logic [7:0]        LAST_BEAT = 8'(BURST_LEN - 1);

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     fill_q;
    logic [7:0]          beat_cnt;
    logic                wr_req_q;
    logic                rd_req_q;
    logic                bb_q;
    logic                ob_we_q;
    logic [DATA_W-1:0]   ob_data_q;
    logic                ovf_q;
    logic                prefer_wr;   // round-robin token: 1 = write wins a tie
`ifdef DDR_STREAM_STATS_EN
    logic [31:0]         stat_wr_q;
    logic [31:0]         stat_rd_q;
`endif

    // Eligibility. Comparisons use a two-bit-wider range so fill + BURST_LEN
    // cannot wrap.
    logic [ADDR_W+1:0]   fill_ext;
    logic [ADDR_W+1:0]   region_ext;
    logic                ring_room;
    logic                wr_ok;
    logic                rd_ok;
    logic                grant_wr;
    logic                grant_rd;
    logic                wr_accept;
    logic                rd_accept;
    logic                last_beat;
    logic                overflow_evt;
    logic [ADDR_W:0]     wr_sum;
    logic [ADDR_W:0]     rd_sum;
    logic [ADDR_W-1:0]   wr_ptr_nxt;
    logic [ADDR_W-1:0]   rd_ptr_nxt;

    assign fill_ext   = {1'b0, fill_q};
    assign region_ext = {2'b00, region_words};
    assign ring_room  = (fill_ext + BL_EXT) <= region_ext;

    assign wr_ok = calib_done & writes_en
                 & (ib_count >= CNT_W'(BURST_LEN)) & ring_room;
    assign rd_ok = calib_done & reads_en
                 & (fill_ext >= BL_EXT)
                 & (ob_count <= CNT_W'(FIFO_DEPTH - 1 - BURST_LEN));

    assign grant_wr = wr_ok & (~rd_ok | prefer_wr);
    assign grant_rd = rd_ok & (~wr_ok | ~prefer_wr);

    // Requests are only ever high in their own state, so the request flag
    // alone qualifies acceptance.
    assign wr_accept = wr_req_q & avl.avl_ready;
    assign rd_accept = rd_req_q & avl.avl_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);

    assign overflow_evt = ~ring_room & writes_en
                        & (ib_count == CNT_W'(FIFO_DEPTH));

    // Pointer advance with wrap back to the ring start.
    assign wr_sum     = {1'b0, wr_ptr} + BL_FILL;
    assign rd_sum     = {1'b0, rd_ptr} + BL_FILL;
    assign wr_ptr_nxt = (wr_sum == {1'b0, region_words}) ? '0 : wr_sum[ADDR_W-1:0];
    assign rd_ptr_nxt = (rd_sum == {1'b0, region_words}) ? '0 : rd_sum[ADDR_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            addr_q    <= '0;
            fill_q    <= '0;
            beat_cnt  <= '0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            bb_q      <= 1'b0;
            ob_we_q   <= 1'b0;
            ob_data_q <= '0;
            ovf_q     <= 1'b0;
            prefer_wr <= 1'b1;
`ifdef DDR_STREAM_STATS_EN
            stat_wr_q <= '0;
            stat_rd_q <= '0;
`endif
        end else begin
            ob_we_q <= 1'b0;
            if (overflow_evt) begin
                ovf_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (clear) begin
                        // Clear wins over a same-cycle grant and overflow set.
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        fill_q <= '0;
                        ovf_q  <= 1'b0;
`ifdef DDR_STREAM_STATS_EN
                        stat_wr_q <= '0;
                        stat_rd_q <= '0;
`endif
                    end else if (grant_wr) begin
                        addr_q    <= region_base + wr_ptr;
                        wr_req_q  <= 1'b1;
                        bb_q      <= 1'b1;
                        beat_cnt  <= '0;
                        prefer_wr <= 1'b0;
                        state     <= WR_BURST;
                    end else if (grant_rd) begin
                        addr_q    <= region_base + rd_ptr;
                        rd_req_q  <= 1'b1;
                        bb_q      <= 1'b1;
                        prefer_wr <= 1'b1;
                        state     <= RD_CMD;
                    end
                end

                WR_BURST: begin
                    if (wr_accept) begin
                        bb_q     <= 1'b0;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (last_beat) begin
                            wr_req_q <= 1'b0;
                            wr_ptr   <= wr_ptr_nxt;
                            fill_q   <= fill_q + BL_FILL;
                            state    <= IDLE;
`ifdef DDR_STREAM_STATS_EN
                            if (stat_wr_q != '1) begin
                                stat_wr_q <= stat_wr_q + 32'd1;
                            end
`endif
                        end
                    end
                end

                RD_CMD: begin
                    if (rd_accept) begin
                        rd_req_q <= 1'b0;
                        bb_q     <= 1'b0;
                        rd_ptr   <= rd_ptr_nxt;
                        fill_q   <= fill_q - BL_FILL;
                        beat_cnt <= '0;
                        state    <= RD_DATA;
`ifdef DDR_STREAM_STATS_EN
                        if (stat_rd_q != '1) begin
                            stat_rd_q <= stat_rd_q + 32'd1;
                        end
`endif
                    end
                end

                RD_DATA: begin
                    if (avl.avl_rdata_valid) begin
                        ob_data_q <= avl.avl_rdata;
                        ob_we_q   <= 1'b1;
                        beat_cnt  <= beat_cnt + 8'd1;
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign ib_re      = wr_accept;
    assign ob_we      = ob_we_q;
    assign ob_data    = ob_data_q;
    assign fill_words = fill_q;
    assign overflow   = ovf_q;
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    assign avl.avl_burstbegin = bb_q;
    assign avl.avl_address    = addr_q;
    assign avl.avl_size       = 8'(BURST_LEN);
    assign avl.avl_read_req   = rd_req_q;
    assign avl.avl_write_req  = wr_req_q;
    assign avl.avl_wdata      = ib_data;   // show-ahead head word
    assign avl.avl_be         = '1;

`ifdef DDR_STREAM_STATS_EN
    assign stat_wr_bursts = stat_wr_q;
    assign stat_rd_bursts = stat_rd_q;
`endif

endmodule
